// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiator: FSM state encoding and
// the bit-index width helper.
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RED,
        SQR,
        MUL,
        NEXT,
        DONE
    } state_e;

    // Never returns 0, so a 1-bit exponent still gets a usable index register.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 31; k++) begin
            if ((32'd1 << k) < v) r = k + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/modexp_engine_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m in WIDTH+1 cycles
// from go to the cycle after rdy is seen (requires b < m).
module modmul_serial
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             rdy
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH+1:0] p_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, rdy_q;

    // One MSB-first step: P < m and b < m keep 2P + b below 3m, so two
    // conditional subtractions always bring P back under m.
    function automatic logic [WIDTH+1:0] step(input logic [WIDTH+1:0] acc,
                                              input logic             ak,
                                              input logic [WIDTH-1:0] bv,
                                              input logic [WIDTH-1:0] mv);
        logic [WIDTH+1:0] t, mx;
        mx = {2'b00, mv};
        t  = {acc[WIDTH:0], 1'b0} + (ak ? {2'b00, bv} : '0);
        if (t >= mx) t = t - mx;
        if (t >= mx) t = t - mx;
        return t;
    endfunction

    // The go cycle already performs the first (MSB) iteration from P=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (go) begin
                p_q   <= step('0, a[WIDTH-1], b, m);
                a_q   <= a << 1;
                b_q   <= b;
                m_q   <= m;
                cnt_q <= ITER_LAST;
                run_q <= (WIDTH > 1);
                rdy_q <= (WIDTH == 1);
            end else if (run_q) begin
                p_q   <= step(p_q, a_q[WIDTH-1], b_q, m_q);
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    run_q <= 1'b0;
                    rdy_q <= 1'b1;
                end
            end
        end
    end

    assign p   = p_q[WIDTH-1:0];
    assign rdy = rdy_q;

endmodule

// File: rtl/modexp_engine.sv
// Left-to-right square-and-multiply modular exponentiator (base^exponent mod modulus).
// Define MODEXP_CONST_TIME_EN for exponent-independent latency (always executes MUL).
module modexp_engine
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned   IW    = clog2(EXP_WIDTH);
    localparam logic [IW-1:0] I_TOP = IW'(EXP_WIDTH - 1);
`ifdef MODEXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    state_e               state_q;
    logic [WIDTH-1:0]     base_q, mod_q, b_q, acc_q, result_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [IW-1:0]        i_q;
    logic                 go_q, err_pend_q, err_q, busy_q, done_q;

    logic [WIDTH-1:0]     mm_a, mm_b, mm_p;
    logic                 mm_rdy;

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            RED: begin
                mm_a = base_q;
                mm_b = WIDTH'(1);
            end
            SQR: begin
                mm_a = acc_q;
                mm_b = acc_q;
            end
            MUL: begin
                mm_a = acc_q;
                mm_b = b_q;
            end
            default: ;
        endcase
    end

    modmul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (go_q),
        .a   (mm_a),
        .b   (mm_b),
        .m   (mod_q),
        .p   (mm_p),
        .rdy (mm_rdy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            mod_q      <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            i_q        <= '0;
            go_q       <= 1'b0;
            err_pend_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        base_q  <= base;
                        exp_q   <= exponent;
                        mod_q   <= modulus;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mod_q == '0) begin
                        acc_q      <= '0;
                        err_pend_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (mod_q == WIDTH'(1)) begin
                        acc_q      <= '0;
                        err_pend_q <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        acc_q      <= WIDTH'(1);
                        err_pend_q <= 1'b0;
                        go_q       <= 1'b1;
                        state_q    <= RED;
                    end
                end
                RED: if (mm_rdy) begin
                    b_q     <= mm_p;
                    i_q     <= I_TOP;
                    go_q    <= 1'b1;
                    state_q <= SQR;
                end
                SQR: if (mm_rdy) begin
                    acc_q <= mm_p;
                    if (exp_q[i_q] || CONST_TIME) begin
                        go_q    <= 1'b1;
                        state_q <= MUL;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                // In constant-time builds a zero bit still runs MUL; the product is dropped.
                MUL: if (mm_rdy) begin
                    if (exp_q[i_q]) acc_q <= mm_p;
                    state_q <= NEXT;
                end
                NEXT: begin
                    if (i_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_q - 1'b1;
                        go_q    <= 1'b1;
                        state_q <= SQR;
                    end
                end
                DONE: begin
                    result_q <= acc_q;
                    err_q    <= err_pend_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
